// File: rtl/floo_axis_rx_pkg.sv
// floo_axis_rx_pkg
// Shared definitions for the receive-side AXIS-to-NoC demultiplexer.
//   cls_e          : traffic class of a beat / credit (ClsRsp = 0, ClsReq = 1)
//   flit_payload_t : layout of one AXIS beat, {hdr, flit_data}, at the default width
//   pend_w()       : width of a counter that must hold the values 0..depth
package floo_axis_rx_pkg;

   localparam int unsigned FlitDataWidthDefault = 64;

   typedef enum logic {
      ClsRsp = 1'b0,
      ClsReq = 1'b1
   } cls_e;

   typedef struct packed {
      logic                            hdr;
      logic [FlitDataWidthDefault-1:0] flit_data;
   } flit_payload_t;

   // A pending-credit counter can reach depth itself, so it needs one extra value
   function automatic int unsigned pend_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/floo_axis_rx_class_fifo.sv
// floo_axis_rx_class_fifo
// Non-fall-through synchronous FIFO holding the flits of one traffic class.
// A push is visible at the head one cycle later. A push into a full FIFO is
// taken only when a pop frees a slot in the same cycle; otherwise it is
// dropped and flagged on drop_o.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset (empties the FIFO)
//   push_i            : write request
//   push_data_i       : write data
//   full_o            : registered full state
//   drop_o            : push refused this cycle (full and no pop)
//   pop_valid_o       : head flit valid
//   pop_ready_i       : consumer accepts the head flit
//   pop_data_o        : head flit, stable while stalled
module floo_axis_rx_class_fifo
   import floo_axis_rx_pkg::*;
#(
   parameter int unsigned Width = 64,
   parameter int unsigned Depth = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [Width-1:0] push_data_i,
   output logic             full_o,
   output logic             drop_o,
   output logic             pop_valid_o,
   input  logic             pop_ready_i,
   output logic [Width-1:0] pop_data_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = pend_w(Depth);
   localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
   localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

   logic [Width-1:0] r_mem [Depth];
   logic [PtrW-1:0]  r_wrPtr;
   logic [PtrW-1:0]  r_rdPtr;
   logic [CntW-1:0]  r_count;
   logic             w_full;
   logic             w_push;
   logic             w_pop;

   assign w_full      = (r_count == FullCnt);
   assign w_pop       = (r_count != '0) && pop_ready_i;
   assign w_push      = push_i && (!w_full || w_pop);
   assign full_o      = w_full;
   assign drop_o      = push_i && w_full && !w_pop;
   assign pop_valid_o = (r_count != '0);
   assign pop_data_o  = r_mem[r_rdPtr];

   // Pointers wrap explicitly so non-power-of-two depths work; a simultaneous
   // push and pop leaves the occupancy unchanged, including when full.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= (r_wrPtr == LastPtr) ? '0 : r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= (r_rdPtr == LastPtr) ? '0 : r_rdPtr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= push_data_i;
      end
   end

endmodule

// File: rtl/floo_axis_noc_rx_demux.sv
// floo_axis_noc_rx_demux
// Receive-side AXIS-to-NoC demultiplexer. Each AXIS beat {hdr, flit_data} is
// steered into the request FIFO (hdr = 1) or the response FIFO (hdr = 0); the
// two classes drain independently to the local NoC.
// Configuration macro FLOO_AXIS_RX_CREDIT_EN:
//   defined   : tready is always high outside reset, beats hitting a full FIFO
//               are dropped and set overflow_o, freed slots are returned as
//               credits with round-robin class selection.
//   undefined : tready follows the full state of the FIFO picked by hdr;
//               overflow and the credit port are tied low.
// Ports:
//   clk_i, rst_i                          : clock, synchronous active-high reset
//   axis_tvalid_i/axis_tready_o/axis_tdata_i : incoming AXIS beats
//   req_valid_o/req_ready_i/req_data_o    : request flit channel
//   rsp_valid_o/rsp_ready_i/rsp_data_o    : response flit channel
//   credit_valid_o/credit_ready_i         : credit token handshake
//   credit_cls_o                          : credit class, 1 = req, 0 = rsp
//   overflow_o                            : sticky write-to-full error
module floo_axis_noc_rx_demux
   import floo_axis_rx_pkg::*;
#(
   parameter int unsigned FlitDataWidth = 64,
   parameter int unsigned ReqDepth      = 4,
   parameter int unsigned RspDepth      = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     axis_tvalid_i,
   output logic                     axis_tready_o,
   input  logic [FlitDataWidth:0]   axis_tdata_i,
   output logic                     req_valid_o,
   input  logic                     req_ready_i,
   output logic [FlitDataWidth-1:0] req_data_o,
   output logic                     rsp_valid_o,
   input  logic                     rsp_ready_i,
   output logic [FlitDataWidth-1:0] rsp_data_o,
   output logic                     credit_valid_o,
   input  logic                     credit_ready_i,
   output logic                     credit_cls_o,
   output logic                     overflow_o
);

   logic                     w_hdr;
   logic [FlitDataWidth-1:0] w_flit;
   logic                     w_tready;
   logic                     w_accept;
   logic                     w_reqFull;
   logic                     w_rspFull;
   logic                     w_reqDrop;
   logic                     w_rspDrop;
   logic                     w_reqHeadValid;
   logic                     w_rspHeadValid;
   logic [FlitDataWidth-1:0] w_reqHeadData;
   logic [FlitDataWidth-1:0] w_rspHeadData;
   logic                     w_reqPop;
   logic                     w_rspPop;

   assign w_hdr  = axis_tdata_i[FlitDataWidth];
   assign w_flit = axis_tdata_i[FlitDataWidth-1:0];

`ifdef FLOO_AXIS_RX_CREDIT_EN
   assign w_tready = 1'b1;
`else
   // Only registered full state and hdr feed tready, never the NoC readies
   assign w_tready = w_hdr ? !w_reqFull : !w_rspFull;
`endif

   // Every output is forced low while reset is asserted
   assign axis_tready_o = w_tready && !rst_i;
   assign w_accept      = axis_tvalid_i && axis_tready_o;

   assign req_valid_o = w_reqHeadValid && !rst_i;
   assign rsp_valid_o = w_rspHeadValid && !rst_i;
   assign req_data_o  = rst_i ? '0 : w_reqHeadData;
   assign rsp_data_o  = rst_i ? '0 : w_rspHeadData;
   assign w_reqPop    = req_valid_o && req_ready_i;
   assign w_rspPop    = rsp_valid_o && rsp_ready_i;

   floo_axis_rx_class_fifo #(
      .Width (FlitDataWidth),
      .Depth (ReqDepth)
   ) u_reqFifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (w_accept && w_hdr),
      .push_data_i (w_flit),
      .full_o      (w_reqFull),
      .drop_o      (w_reqDrop),
      .pop_valid_o (w_reqHeadValid),
      .pop_ready_i (w_reqPop),
      .pop_data_o  (w_reqHeadData)
   );

   floo_axis_rx_class_fifo #(
      .Width (FlitDataWidth),
      .Depth (RspDepth)
   ) u_rspFifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (w_accept && !w_hdr),
      .push_data_i (w_flit),
      .full_o      (w_rspFull),
      .drop_o      (w_rspDrop),
      .pop_valid_o (w_rspHeadValid),
      .pop_ready_i (w_rspPop),
      .pop_data_o  (w_rspHeadData)
   );

`ifdef FLOO_AXIS_RX_CREDIT_EN
   localparam int unsigned ReqPendW = pend_w(ReqDepth);
   localparam int unsigned RspPendW = pend_w(RspDepth);
   localparam logic [ReqPendW-1:0] ReqPendMax = ReqPendW'(ReqDepth);
   localparam logic [RspPendW-1:0] RspPendMax = RspPendW'(RspDepth);

   logic [ReqPendW-1:0] r_reqPend;
   logic [RspPendW-1:0] r_rspPend;
   cls_e                r_rrPtr;
   cls_e                r_heldCls;
   logic                r_hold;
   logic                r_overflow;
   cls_e                w_credCls;
   logic                w_credValid;
   logic                w_credHs;
   logic                w_reqCredHs;
   logic                w_rspCredHs;

   assign w_credValid = (r_reqPend != '0) || (r_rspPend != '0);

   // A stalled offer keeps its class; only a handshake decrements a counter,
   // so the held class is guaranteed to still have a pending credit.
   always_comb begin
      w_credCls = ClsRsp;
      if (r_hold) begin
         w_credCls = r_heldCls;
      end else if ((r_reqPend != '0) && (r_rspPend != '0)) begin
         w_credCls = r_rrPtr;
      end else if (r_reqPend != '0) begin
         w_credCls = ClsReq;
      end
   end

   assign credit_valid_o = w_credValid && !rst_i;
   assign credit_cls_o   = (w_credCls == ClsReq) && !rst_i;
   assign overflow_o     = r_overflow && !rst_i;
   assign w_credHs       = credit_valid_o && credit_ready_i;
   assign w_reqCredHs    = w_credHs && (w_credCls == ClsReq);
   assign w_rspCredHs    = w_credHs && (w_credCls == ClsRsp);

   // Pending counters, round-robin pointer, stall hold and sticky overflow.
   // A pop and a credit of the same class in one cycle cancel out.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_reqPend  <= '0;
         r_rspPend  <= '0;
         r_rrPtr    <= ClsReq;
         r_heldCls  <= ClsReq;
         r_hold     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_reqPop && !w_reqCredHs && (r_reqPend != ReqPendMax)) begin
            r_reqPend <= r_reqPend + 1'b1;
         end else if (!w_reqPop && w_reqCredHs) begin
            r_reqPend <= r_reqPend - 1'b1;
         end
         if (w_rspPop && !w_rspCredHs && (r_rspPend != RspPendMax)) begin
            r_rspPend <= r_rspPend + 1'b1;
         end else if (!w_rspPop && w_rspCredHs) begin
            r_rspPend <= r_rspPend - 1'b1;
         end
         if (w_credHs) begin
            r_rrPtr <= (w_credCls == ClsReq) ? ClsRsp : ClsReq;
         end
         r_hold    <= w_credValid && !credit_ready_i;
         r_heldCls <= w_credCls;
         if (w_reqDrop || w_rspDrop) begin
            r_overflow <= 1'b1;
         end
      end
   end
`else
   logic w_unusedBits;

   assign w_unusedBits   = credit_ready_i ^ w_reqDrop ^ w_rspDrop ^ w_reqPop ^ w_rspPop;
   assign credit_valid_o = 1'b0;
   assign credit_cls_o   = 1'b0;
   assign overflow_o     = 1'b0;
`endif

endmodule
